rm_alert_queue: RTL and testbench

Downstream consumer of rm_monitor's per-lane rule-hit matrix (monitor_o). Detects new rule hits (rising edges), serialises simultaneous hits, and queues alert records {lane, rule, timestamp} in a FIFO. The FIFO drains over a valid/ready interface to the CSR/trap logic, and a level interrupt is raised while alerts are queued. Hits that cannot be recorded are counted as drops.

---
 rtl/ariane_pkg.sv | 34 +++
 rtl/rm_alert_fifo.sv | 83 ++++++++
 rtl/rm_alert_queue.sv | 169 ++++++++++++++++
 tb/tb_rm_alert_queue.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ariane_pkg.sv
// ---------------------------------------------------------------------------
// ariane_pkg
//
// Shared types and default sizes for the rm_alert_queue slice.
//
// Contents:
//   RM_* localparams  - default rm_monitor geometry and alert queue sizes
//   RM_LW / RM_RW     - lane / rule index widths, max(1, clog2(n))
//   rm_alert_t        - one queued alert record {lane, rule[, ts]}
//
// Configuration macro: RM_ALERT_TIMESTAMP_EN
//   Defined   - records carry a RM_TS_WIDTH timestamp field.
//   Undefined - records hold lane and rule only (no timestamp storage).
// ---------------------------------------------------------------------------
package ariane_pkg;

    localparam int unsigned RM_NUM_LANES      = 7;
    localparam int unsigned RM_NUM_RULES      = 10;
    localparam int unsigned RM_FIFO_DEPTH     = 8;
    localparam int unsigned RM_TS_WIDTH       = 16;
    localparam int unsigned RM_DROP_CNT_WIDTH = 8;

    localparam int unsigned RM_LW = (RM_NUM_LANES > 1) ? $clog2(RM_NUM_LANES) : 1;
    localparam int unsigned RM_RW = (RM_NUM_RULES > 1) ? $clog2(RM_NUM_RULES) : 1;

    typedef struct packed {
        logic [RM_LW-1:0]       lane;
        logic [RM_RW-1:0]       rule;
`ifdef RM_ALERT_TIMESTAMP_EN
        logic [RM_TS_WIDTH-1:0] ts;
`endif
    } rm_alert_t;

endpackage

// File: rtl/rm_alert_fifo.sv
// ---------------------------------------------------------------------------
// rm_alert_fifo
//
// Generic first-word-fall-through FIFO. Storage and pointers are registers;
// the head element is read straight out of the storage array so it is
// visible in the same cycle it becomes valid.
//
// Ports:
//   clk_i, rst_i  - clock, synchronous active-high reset
//   push_i/data_i - write request and element; ignored when full unless a
//                   pop happens in the same cycle
//   pop_i         - remove head element; ignored when empty
//   data_o        - head element, forced to 0 while empty
//   full_o        - DEPTH elements held
//   empty_o       - no element held
//   count_o       - occupancy, 0..DEPTH
//
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module rm_alert_fifo #(
    parameter type         T     = logic,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  T                         data_i,
    input  logic                     pop_i,
    output T                         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    T               mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [AW:0]    count_q,  count_d;
    logic           do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A push into a full FIFO is legal only because the head leaves at the
    // same edge; occupancy then stays unchanged.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/rm_alert_queue.sv
// ---------------------------------------------------------------------------
// rm_alert_queue
//
// Turns rising edges of rm_monitor's lane x rule hit matrix into a queue of
// alert records. Simultaneous hits are parked in a pending matrix and
// granted one per cycle, lowest flat index (lane*NUM_RULES+rule) first. A
// hit that re-rises while its pending bit is still waiting is dropped and
// counted in a saturating counter.
//
// Ports:
//   clk_i, rst_i   - clock, synchronous active-high reset
//   monitor_i      - [NUM_LANES][NUM_RULES] rule-hit matrix
//   enable_i       - accept new rising edges when high
//   clear_drop_i   - reload drop counter with this cycle's drops only
//   alert_valid_o  - head record valid (valid/ready: a record transfers on
//   alert_ready_i    any edge where both are high; head stays stable while
//                    valid && !ready)
//   alert_lane_o   - lane of head record
//   alert_rule_o   - rule of head record
//   alert_ts_o     - timestamp of head record (0 without timestamps)
//   irq_o          - high while any record is queued
//   fifo_cnt_o     - queue occupancy
//   drop_cnt_o     - saturating count of dropped hits
//
// Configuration macro: RM_ALERT_TIMESTAMP_EN
//   Defined   - free-running TS_WIDTH counter stamped into each record.
//   Undefined - no counter; alert_ts_o is tied to 0.
//
// Record field widths come from ariane_pkg; the parameters below are meant
// to stay at the package defaults.
// ---------------------------------------------------------------------------
module rm_alert_queue
    import ariane_pkg::*;
#(
    parameter int unsigned NUM_LANES      = RM_NUM_LANES,
    parameter int unsigned NUM_RULES      = RM_NUM_RULES,
    parameter int unsigned FIFO_DEPTH     = RM_FIFO_DEPTH,
    parameter int unsigned TS_WIDTH       = RM_TS_WIDTH,
    parameter int unsigned DROP_CNT_WIDTH = RM_DROP_CNT_WIDTH
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic [NUM_LANES-1:0][NUM_RULES-1:0]   monitor_i,
    input  logic                                  enable_i,
    input  logic                                  clear_drop_i,
    output logic                                  alert_valid_o,
    input  logic                                  alert_ready_i,
    output logic [RM_LW-1:0]                      alert_lane_o,
    output logic [RM_RW-1:0]                      alert_rule_o,
    output logic [TS_WIDTH-1:0]                   alert_ts_o,
    output logic                                  irq_o,
    output logic [$clog2(FIFO_DEPTH):0]           fifo_cnt_o,
    output logic [DROP_CNT_WIDTH-1:0]             drop_cnt_o
);

    localparam int unsigned FLAT = NUM_LANES * NUM_RULES;
    localparam int unsigned PW   = $clog2(FLAT + 1);
    localparam int unsigned SW   = ((DROP_CNT_WIDTH > PW) ? DROP_CNT_WIDTH : PW) + 1;

    logic [FLAT-1:0]           mon_flat;
    logic [FLAT-1:0]           prev_q,    prev_d;
    logic [FLAT-1:0]           pending_q, pending_d;
    logic [FLAT-1:0]           rise, grant, drops;
    logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
    logic [PW-1:0]             drop_sum;
    logic [SW-1:0]             drop_acc;
    logic                      push, pop, found;
    logic                      fifo_full, fifo_empty;
    rm_alert_t                 grant_rec, head;

`ifdef RM_ALERT_TIMESTAMP_EN
    logic [TS_WIDTH-1:0]       ts_q, ts_d;
    assign ts_d = ts_q + 1'b1;
`endif

    assign mon_flat = monitor_i;
    assign prev_d   = mon_flat;
    assign rise     = enable_i ? (mon_flat & ~prev_q) : '0;
    assign pop      = alert_valid_o && alert_ready_i;

    // Priority encoder over the pending matrix. Space is checked up front so
    // a grant always results in a push.
    always_comb begin
        grant     = '0;
        grant_rec = '0;
        found     = 1'b0;
        if ((pending_q != '0) && (!fifo_full || pop)) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                for (int r = 0; r < NUM_RULES; r++) begin
                    if (!found && pending_q[l*NUM_RULES + r]) begin
                        found                      = 1'b1;
                        grant[l*NUM_RULES + r]     = 1'b1;
                        grant_rec.lane             = RM_LW'(l);
                        grant_rec.rule             = RM_RW'(r);
                    end
                end
            end
        end
`ifdef RM_ALERT_TIMESTAMP_EN
        grant_rec.ts = ts_q;
`endif
    end

    assign push      = found;
    assign pending_d = (pending_q & ~grant) | rise;
    // A re-rise onto a still-waiting bit has nowhere to go.
    assign drops     = rise & pending_q & ~grant;

    always_comb begin
        drop_sum = '0;
        for (int i = 0; i < FLAT; i++) begin
            drop_sum = drop_sum + PW'(drops[i]);
        end
    end

    // Clear restarts the count from this cycle's drops instead of zero so
    // no drop is lost across a clear.
    always_comb begin
        drop_acc = (clear_drop_i ? '0 : SW'(drop_cnt_q)) + SW'(drop_sum);
        if (|drop_acc[SW-1:DROP_CNT_WIDTH]) drop_cnt_d = '1;
        else                                drop_cnt_d = drop_acc[DROP_CNT_WIDTH-1:0];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_q     <= '0;
            pending_q  <= '0;
            drop_cnt_q <= '0;
`ifdef RM_ALERT_TIMESTAMP_EN
            ts_q       <= '0;
`endif
        end else begin
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            drop_cnt_q <= drop_cnt_d;
`ifdef RM_ALERT_TIMESTAMP_EN
            ts_q       <= ts_d;
`endif
        end
    end

    rm_alert_fifo #(
        .T     (rm_alert_t),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .data_i  (grant_rec),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_cnt_o)
    );

    assign alert_valid_o = !fifo_empty;
    assign alert_lane_o  = head.lane;
    assign alert_rule_o  = head.rule;
`ifdef RM_ALERT_TIMESTAMP_EN
    assign alert_ts_o    = head.ts;
`else
    assign alert_ts_o    = '0;
`endif
    // Decoded from the registered occupancy, so it changes only at edges.
    assign irq_o         = (fifo_cnt_o != '0);
    assign drop_cnt_o    = drop_cnt_q;

endmodule

// File: tb/tb_rm_alert_queue.sv
module tb_rm_alert_queue;

  logic                 clk;
  logic                 rst;
  logic [6:0][9:0]      mon;
  logic                 enable;
  logic                 clear_drop;
  logic                 alert_valid;
  logic                 alert_ready;
  logic [2:0]           alert_lane;
  logic [3:0]           alert_rule;
  logic [15:0]          alert_ts;
  logic                 irq;
  logic [3:0]           fifo_cnt;
  logic [7:0]           drop_cnt;

  int tests_run;
  int tests_failed;
  logic [15:0] ts_a;
  logic [15:0] ts_diff;

  rm_alert_queue dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .monitor_i     (mon),
    .enable_i      (enable),
    .clear_drop_i  (clear_drop),
    .alert_valid_o (alert_valid),
    .alert_ready_i (alert_ready),
    .alert_lane_o  (alert_lane),
    .alert_rule_o  (alert_rule),
    .alert_ts_o    (alert_ts),
    .irq_o         (irq),
    .fifo_cnt_o    (fifo_cnt),
    .drop_cnt_o    (drop_cnt)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance one edge, then settle away from it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input int lane, input int rule);
    chk({tag, "_valid"}, 32'(alert_valid), 32'd1);
    chk({tag, "_lane"},  32'(alert_lane),  32'(lane));
    chk({tag, "_rule"},  32'(alert_rule),  32'(rule));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst          = 1'b1;
    mon          = '0;
    enable       = 1'b0;
    clear_drop   = 1'b0;
    alert_ready  = 1'b0;

    // reset state
    tick();
    tick();
    chk("rst_valid", 32'(alert_valid), 32'd0);
    chk("rst_irq",   32'(irq),         32'd0);
    chk("rst_cnt",   32'(fifo_cnt),    32'd0);
    chk("rst_drop",  32'(drop_cnt),    32'd0);
    chk("rst_lane",  32'(alert_lane),  32'd0);
    chk("rst_rule",  32'(alert_rule),  32'd0);
    chk("rst_ts",    32'(alert_ts),    32'd0);

    rst         = 1'b0;
    enable      = 1'b1;
    alert_ready = 1'b1;
    tick();
    tick();

    // single hit: two edges of latency, popped immediately
    mon[2][5] = 1'b1;
    tick();
    chk("t1_lat_valid", 32'(alert_valid), 32'd0);
    tick();
    chk_head("t1", 2, 5);
    chk("t1_irq", 32'(irq), 32'd1);
    chk("t1_cnt", 32'(fifo_cnt), 32'd1);
    tick();
    chk("t1_done_valid", 32'(alert_valid), 32'd0);
    chk("t1_done_irq",   32'(irq),         32'd0);
    chk("t1_drop",       32'(drop_cnt),    32'd0);
    mon = '0;
    tick();

    // three simultaneous hits serialise lowest index first
    mon[0][3] = 1'b1;
    mon[0][1] = 1'b1;
    mon[6][9] = 1'b1;
    tick();
    tick();
    chk_head("t2_a", 0, 1);
    tick();
    chk_head("t2_b", 0, 3);
    tick();
    chk_head("t2_c", 6, 9);
    tick();
    chk("t2_empty", 32'(alert_valid), 32'd0);
    mon = '0;
    tick();

    // back-pressure: nine rises into an eight-deep queue
    alert_ready = 1'b0;
    for (int r = 0; r < 9; r++) begin
      mon[4][r] = 1'b1;
      tick();
    end
    tick();
    tick();
    chk("t3_full_cnt", 32'(fifo_cnt), 32'd8);
    chk("t3_full_irq", 32'(irq),      32'd1);
    chk_head("t3_stable", 4, 0);
    alert_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      chk_head($sformatf("t3_drain%0d", i), 4, i);
      tick();
    end
    chk("t3_end_valid", 32'(alert_valid), 32'd0);
    chk("t3_end_cnt",   32'(fifo_cnt),    32'd0);
    chk("t3_drop",      32'(drop_cnt),    32'd0);
    mon         = '0;
    alert_ready = 1'b0;
    tick();

    // re-rise of a still-pending bit is dropped, then clear
    mon[5][7:0] = 8'hff;
    for (int i = 0; i < 10; i++) tick();
    chk("t4_full_cnt", 32'(fifo_cnt), 32'd8);
    mon[1][1] = 1'b1;
    tick();
    mon[1][1] = 1'b0;
    tick();
    mon[1][1] = 1'b1;
    tick();
    chk("t4_drop1", 32'(drop_cnt), 32'd1);
    tick();
    chk("t4_drop_hold", 32'(drop_cnt), 32'd1);
    clear_drop = 1'b1;
    tick();
    clear_drop = 1'b0;
    chk("t4_clear", 32'(drop_cnt), 32'd0);
    alert_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) chk_head($sformatf("t4_drain%0d", i), 5, i);
      else       chk_head("t4_drain8", 1, 1);
      tick();
    end
    chk("t4_end_valid", 32'(alert_valid), 32'd0);
    mon = '0;
    tick();

    // rise while disabled never produces an alert
    enable    = 1'b0;
    mon[3][0] = 1'b1;
    tick();
    tick();
    enable = 1'b1;
    tick();
    tick();
    tick();
    chk("t5_valid", 32'(alert_valid), 32'd0);
    chk("t5_cnt",   32'(fifo_cnt),    32'd0);
    mon = '0;
    tick();

    // reset mid-operation discards, held bit fires exactly once after
    alert_ready = 1'b0;
    mon[6][0]   = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_pre_cnt", 32'(fifo_cnt), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_rst_cnt",   32'(fifo_cnt),    32'd0);
    chk("t6_rst_valid", 32'(alert_valid), 32'd0);
    tick();
    tick();
    chk_head("t6_refire", 6, 0);
    alert_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("t6_once", 32'(alert_valid), 32'd0);
    mon = '0;
    tick();

    // two pushes four cycles apart
    alert_ready = 1'b0;
    mon[0][0]   = 1'b1;
    tick();
    tick();
    tick();
    tick();
    mon[0][2] = 1'b1;
    tick();
    tick();
    tick();
    chk("t7_cnt", 32'(fifo_cnt), 32'd2);
    chk_head("t7_a", 0, 0);
    ts_a        = alert_ts;
    alert_ready = 1'b1;
    tick();
    chk_head("t7_b", 0, 2);
`ifdef RM_ALERT_TIMESTAMP_EN
    ts_diff = alert_ts - ts_a;
    chk("t7_ts_delta", 32'(ts_diff), 32'd4);
`else
    chk("t7_ts_a_zero", 32'(ts_a),     32'd0);
    chk("t7_ts_b_zero", 32'(alert_ts), 32'd0);
`endif
    tick();
    chk("t7_empty", 32'(alert_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
